// File: rtl/corelet_pkg.sv
// Shared corelet types: drain FSM states and array mode encodings.
package corelet_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drain_state_t;

   localparam logic MODE_WS = 1'b0;
   localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/tile_drain_ctrl_relu_lane.sv
// Single-lane ReLU clamp: negative (sign bit set) values become zero when enabled.
module relu_lane #(
   parameter int PSUM_BW = 16
) (
   input  logic               en,
   input  logic [PSUM_BW-1:0] din,
   output logic [PSUM_BW-1:0] dout
);

   assign dout = (en && din[PSUM_BW-1]) ? '0 : din;

endmodule

// File: rtl/tile_drain_ctrl.sv
// MAC-array to OFIFO drain: OS tiles are snapshotted and drained row by row,
// WS rows pass straight through. ReLU clamp built only with TILE_DRAIN_RELU_EN.
module tile_drain_ctrl
   import corelet_pkg::*;
#(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int PSUM_BW = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mode,
   input  logic [PSUM_BW*COL*ROW-1:0] tile_in,
   input  logic [COL-1:0]             tile_valid,
   input  logic [PSUM_BW*COL-1:0]     ws_psum_in,
   input  logic [COL-1:0]             ws_valid,
   input  logic                       relu_en,
   input  logic                       ofifo_full,
   output logic                       ofifo_wr,
   output logic [PSUM_BW*COL-1:0]     ofifo_data,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(ROW)-1:0]     row_idx,
   output logic                       tile_lost,
   output logic                       ws_overflow
);

   localparam int RW = $clog2(ROW);
   localparam int RB = PSUM_BW * COL;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROW - 1);
   localparam logic [RW-1:0] ONE      = RW'(1);

   drain_state_t state, state_nxt;

   logic [ROW-1:0][RB-1:0]          snap;
   logic [RW-1:0]                   row_q;
   logic                            tile_hit, ws_hit;
   logic                            capture, row_wr, wr_c;
   logic [COL-1:0][PSUM_BW-1:0]     raw_row, out_row;

   assign tile_hit = |tile_valid;
   assign ws_hit   = |ws_valid;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      row_wr    = 1'b0;
      wr_c      = 1'b0;
      raw_row   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (mode == MODE_OS) begin
               if (tile_hit) begin
                  capture   = 1'b1;
                  state_nxt = DRAIN;
               end
            end else begin
               wr_c    = ws_hit & ~ofifo_full;
               raw_row = ws_psum_in;
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            raw_row = snap[row_q];
            // Full stalls the current row in place; it is retried, never skipped.
            if (!ofifo_full) begin
               row_wr = 1'b1;
               wr_c   = 1'b1;
               if (row_q == LAST_ROW)
                  state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef TILE_DRAIN_RELU_EN
   for (genvar c = 0; c < COL; c++) begin : g_relu
      relu_lane #(.PSUM_BW(PSUM_BW)) u_relu (
         .en   (relu_en),
         .din  (raw_row[c]),
         .dout (out_row[c])
      );
   end
`else
   logic unused_relu_en;
   assign unused_relu_en = relu_en;
   assign out_row        = raw_row;
`endif

   assign ofifo_wr   = wr_c;
   assign ofifo_data = wr_c ? out_row : '0;
   assign row_idx    = row_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         row_q       <= '0;
         snap        <= '0;
         tile_lost   <= 1'b0;
         ws_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            snap  <= tile_in;
            row_q <= '0;
         end else if (row_wr) begin
            row_q <= (row_q == LAST_ROW) ? '0 : row_q + ONE;
         end
         if ((state == DRAIN || state == DONE) && tile_hit)
            tile_lost <= 1'b1;
         if (state == IDLE && mode == MODE_WS && ws_hit && ofifo_full)
            ws_overflow <= 1'b1;
      end
   end

endmodule
